// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that grants the FIFO write port to one requester for a whole burst.
// Optional owner-idle timeout release is enabled by defining FIFO_WR_ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_MAX  = 16,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                          clk_wr,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          full,
  output logic                          w_valid,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic               found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               owner_valid;
  logic               accept;
  logic               last_beat;
  logic               timeout_hit;
  logic [IDX_W-1:0]   owner_next;

  assign busy        = (state_q == BURST);
  assign owner_valid = req_valid[owner_q];
  assign accept      = busy && owner_valid && !full;
  assign last_beat   = req_last[owner_q] || (beat_cnt_q == CNT_W'(BURST_MAX - 1));
  assign owner_next  = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);

  assign gnt       = gnt_q;
  assign req_ready = accept ? gnt_q : '0;
  assign w_valid   = busy && owner_valid;
  assign w_data    = busy ? req_data[32'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[cand_idx]) begin
        found    = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    gnt_d      = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BURST;
          owner_d    = pick_idx;
          gnt_d      = NUM_REQ'(1) << pick_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if ((accept && last_beat) || timeout_hit) begin
          state_d    = IDLE;
          gnt_d      = '0;
          rr_ptr_d   = owner_next;
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

`ifdef FIFO_WR_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

  // Only unstalled owner-idle cycles count; the release fires on the cycle that would reach TIMEOUT.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;
    if (!busy || owner_valid) begin
      idle_cnt_d = '0;
    end else if (!full) begin
      if (32'(idle_cnt_q) == TIMEOUT - 1) begin
        timeout_hit = 1'b1;
        idle_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters (4 requesters, 32-bit data, bursts of 16).
module tb_fifo_wr_arbiter;

  logic         clk_wr;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic [3:0]   gnt;
  logic         full;
  logic         w_valid;
  logic [31:0]  w_data;
  logic         busy;

  int checks;
  int errors;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(32),
    .BURST_MAX (16),
    .TIMEOUT   (8)
  ) dut (
    .clk_wr   (clk_wr),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .gnt      (gnt),
    .full     (full),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .busy     (busy)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] d, input logic l);
    req_valid[i]          = v;
    req_data[i*32 +: 32]  = d;
    req_last[i]           = l;
  endtask

  // Cycle boundary: 2 time units after the rising edge; checks follow a further #1.
  task automatic step();
    @(posedge clk_wr);
    #2;
  endtask

  logic [3:0]  exp_g [10];
  logic [31:0] exp_d [10];

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    full      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'hA0 + i, 1'b1);

    // Reset with every requester valid
    step(); #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wvalid", w_valid, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_wdata", w_data, 32'h0);

    // Release, then round-robin with single-beat bursts: 0,1,2,3,0 with an IDLE gap each
    step(); rst_n = 1'b1;
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    exp_d = '{32'hA0, 32'h0, 32'hA1, 32'h0, 32'hA2, 32'h0, 32'hA3, 32'h0, 32'hA0, 32'h0};
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 9) req_valid = '0;
      #1;
      chk("rr_gnt", gnt, exp_g[k]);
      chk("rr_wdata", w_data, exp_d[k]);
      chk("rr_busy", busy, (exp_g[k] != 4'b0000));
    end

    // Requester 2 alone, beats A,B,C with last on C
    set_req(2, 1'b1, 32'h0000_000A, 1'b0);
    step(); #1;
    chk("r2_gnt", gnt, 4'b0100);
    chk("r2_wvalid", w_valid, 1'b1);
    chk("r2_ready", req_ready, 4'b0100);
    chk("r2_beatA", w_data, 32'h0000_000A);
    step(); set_req(2, 1'b1, 32'h0000_000B, 1'b0); #1;
    chk("r2_beatB", w_data, 32'h0000_000B);
    step(); set_req(2, 1'b1, 32'h0000_000C, 1'b1); #1;
    chk("r2_beatC", w_data, 32'h0000_000C);
    chk("r2_gnt_hold", gnt, 4'b0100);
    step();
    req_valid = '0;
    set_req(0, 1'b1, 32'h10, 1'b1);
    set_req(1, 1'b1, 32'h11, 1'b1);
    set_req(3, 1'b1, 32'h13, 1'b1);
    #1;
    chk("r2_release", gnt, 4'b0000);
    chk("idle_wvalid", w_valid, 1'b0);
    chk("idle_ready", req_ready, 4'b0000);
    chk("idle_wdata", w_data, 32'h0);
    step(); #1;
    chk("search_from3", gnt, 4'b1000);
    chk("search_wdata", w_data, 32'h13);
    step(); req_valid = '0; #1;
    chk("r3_release", gnt, 4'b0000);

    // Requester 1 never asserts last: released after 16 beats; requester 2 waits
    set_req(1, 1'b1, 32'd100, 1'b0);
    set_req(2, 1'b1, 32'd200, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step(); set_req(1, 1'b1, 32'd100 + 32'(k), 1'b0); #1;
      chk("bmax_gnt", gnt, 4'b0010);
      chk("bmax_wdata", w_data, 32'd100 + 32'(k));
      chk("bmax_ready", req_ready, 4'b0010);
    end
    step(); #1;
    chk("bmax_release", gnt, 4'b0000);
    step(); #1;
    chk("bmax_next_gnt", gnt, 4'b0100);
    chk("bmax_next_wdata", w_data, 32'd200);
    step(); req_valid = '0; #1;
    chk("r2b_release", gnt, 4'b0000);

    // FIFO full for 5 cycles in the middle of a burst from requester 0
    set_req(0, 1'b1, 32'h300, 1'b0);
    step(); #1;
    chk("full_gnt", gnt, 4'b0001);
    chk("full_beat0", w_data, 32'h300);
    step(); set_req(0, 1'b1, 32'h301, 1'b0); full = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin step(); #1; end
      chk("full_ready", req_ready, 4'b0000);
      chk("full_wvalid", w_valid, 1'b1);
      chk("full_wdata", w_data, 32'h301);
      chk("full_gnt_hold", gnt, 4'b0001);
    end
    step(); full = 1'b0; #1;
    chk("unfull_ready", req_ready, 4'b0001);
    chk("unfull_wdata", w_data, 32'h301);
    step(); set_req(0, 1'b1, 32'h302, 1'b1); #1;
    chk("unfull_beat2", w_data, 32'h302);
    step(); req_valid = '0; #1;
    chk("full_release", gnt, 4'b0000);

    // Owner goes quiet after 2 beats while requester 3 waits
    set_req(1, 1'b1, 32'hE0, 1'b0);
    step(); #1;
    chk("to_gnt", gnt, 4'b0010);
    chk("to_beat0", w_data, 32'hE0);
    step(); set_req(1, 1'b1, 32'hE1, 1'b0); #1;
    chk("to_beat1", w_data, 32'hE1);
    step(); req_valid = 4'b1000; #1;
    chk("to_quiet_wvalid", w_valid, 1'b0);
    chk("to_quiet_ready", req_ready, 4'b0000);
    chk("to_quiet_gnt", gnt, 4'b0010);
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    repeat (7) step();
    #1;
    chk("to_hold_8th", gnt, 4'b0010);
    step(); #1;
    chk("to_released", gnt, 4'b0000);
    chk("to_released_busy", busy, 1'b0);
`else
    repeat (100) step();
    #1;
    chk("noto_gnt_held", gnt, 4'b0010);
    chk("noto_busy", busy, 1'b1);
    chk("noto_ready", req_ready, 4'b0000);
`endif

    // Reset in the middle of a grant, arbitration restarts from requester 0
    step();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'hB0 + i, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 4'b0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_wvalid", w_valid, 1'b0);
    chk("midrst_ready", req_ready, 4'b0000);
    step(); rst_n = 1'b1;
    step(); #1;
    chk("midrst_restart", gnt, 4'b0001);
    chk("midrst_wdata", w_data, 32'hB0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing the FIFO write port (2..16).
REQ-002 Parameter DATA_WIDTH, default 32: width of one data beat.
REQ-003 Parameter BURST_MAX, default 16: maximum beats accepted per grant (1..256).
REQ-004 Parameter TIMEOUT, default 8: owner-idle cycles before forced release; used only with FIFO_WR_ARB_TIMEOUT_EN.
REQ-005 clk_wr  input  1  write-domain clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  NUM_REQ  per-requester beat-valid.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_last  input  NUM_REQ  per-requester last-beat-of-burst flag, qualified by req_valid.
REQ-010 req_ready  output  NUM_REQ  per-requester beat-accepted strobe.
REQ-011 gnt  output  NUM_REQ  registered one-hot grant, or all-zero.
REQ-012 full  input  1  FIFO full flag (write domain).
REQ-013 w_valid  output  1  FIFO write request.
REQ-014 w_data  output  DATA_WIDTH  FIFO write data.
REQ-015 busy  output  1  high while a grant is held.

Function
REQ-016 The block SHALL implement two states, IDLE and BURST, with busy = (state == BURST).
REQ-017 In IDLE, if any req_valid bit is set, the block SHALL select the first requester with req_valid high, searching upward from rr_ptr modulo NUM_REQ, and SHALL enter BURST on the next edge with gnt one-hot at that index and beat_cnt = 0.
REQ-018 Grant latency SHALL be exactly one cycle from req_valid sampled in IDLE to gnt asserted.
REQ-019 In BURST, w_valid SHALL equal req_valid[owner], and w_data SHALL equal the owner's req_data slice, combinationally.
REQ-020 In IDLE, w_valid, w_data, and req_ready SHALL all be 0.
REQ-021 req_ready[owner] SHALL equal req_valid[owner] && !full; every other req_ready bit SHALL be 0.
REQ-022 A beat is accepted when req_ready[owner] = 1; each accepted beat SHALL increment beat_cnt by 1.
REQ-023 While full = 1, no beat SHALL be accepted, beat_cnt SHALL hold, and the grant SHALL be held.
REQ-024 An accepted beat with req_last = 1, or an accepted beat with beat_cnt == BURST_MAX-1, SHALL return the block to IDLE on the next edge, clear gnt, and set rr_ptr = (owner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-025 At least one IDLE cycle SHALL separate consecutive grants, including grants to the same requester.
REQ-026 Deassertion of req_valid[owner] mid-burst SHALL NOT release the grant, except as given in REQ-030.
REQ-027 Requests from non-owners SHALL be ignored until the block returns to IDLE; no beat from a non-owner SHALL ever reach w_data.

Reset
REQ-028 While rst_n = 0, the block SHALL force: state = IDLE, gnt = 0, rr_ptr = 0, beat_cnt = 0, idle_cnt = 0, busy = 0, w_valid = 0, w_data = 0, req_ready = 0.
REQ-029 Assertion of rst_n mid-burst SHALL abort the burst immediately; after reset release, arbitration SHALL restart from requester 0.

Configuration
REQ-030 With macro FIFO_WR_ARB_TIMEOUT_EN defined:
- idle_cnt SHALL count consecutive BURST cycles with req_valid[owner] = 0; cycles stalled by full SHALL NOT count, and idle_cnt SHALL clear on any owner valid.
- When idle_cnt reaches TIMEOUT, the block SHALL return to IDLE and advance rr_ptr exactly as in REQ-024, without writing a beat.
- Without the macro, idle_cnt logic SHALL be absent, and the grant SHALL be held until last or BURST_MAX.

Verification
REQ-031 Reset: rst_n = 0 with req_valid = 4'b1111 -> gnt = 0, w_valid = 0, req_ready = 0, busy = 0; 1 cycle after release -> gnt = 4'b0001.
REQ-032 Requester 2 only, beats A,B,C with last on C, full = 0 -> gnt = 4'b0100 one cycle after request; w_data = A,B,C on 3 consecutive cycles; gnt = 0 the next cycle; the next grant search starts at 3.
REQ-033 All four requesters continuously valid with last = 1 -> grant order 0,1,2,3,0, each pair separated by one IDLE cycle.
REQ-034 BURST_MAX = 16, requester 1 never asserts last -> release after the 16th accepted beat; the next grant goes to requester 2 when it is valid.
REQ-035 full held high for 5 cycles mid-burst -> req_ready = 0, w_valid = 1, beat_cnt frozen; the beat sequence continues unbroken after full drops.
REQ-036 TIMEOUT = 8, owner drops req_valid after 2 beats -> with FIFO_WR_ARB_TIMEOUT_EN, gnt clears after 8 idle cycles; without it, gnt is still held after 100 cycles.
